passcode_lock_ctrl: RTL and testbench
=====================================

Name: passcode_lock_ctrl

Overview:
Synchronous, parametrised successor to the 8-digit keypad passcode lock.
- Accepts strobed BCD keypad digits and supports two code-handling modes.
- Program mode: stores a DIGITS-long code.
- Enter mode: compares the entered sequence against the stored code.
- Adds features the previous lock lacked: attempt limit with alarm, clear key, entry inactivity timeout, and auto-relock.
- Sits between the keypad encoder and the output/7-segment display logic.

Parameters:
- DIGITS, 8: passcode length in BCD digits (2..16).
- MAX_ATTEMPTS, 3: consecutive failed entries that raise the alarm (1..15).
- ENTRY_TIMEOUT, 1000: idle cycles allowed mid-sequence before the partial entry is discarded.
- UNLOCK_CYCLES, 500: cycles unlocked is held before auto-relock.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
- key_code  in  4  0-9 = digit, 4'hA = clear, 4'hB-4'hF = ignored.
- mode  in  1  1 = program, 0 = enter; sampled only on the first digit of a sequence.
- relock  in  1  forces UNLOCK -> IDLE.
- alarm_clr  in  1  clears the alarm and the attempt count.
- unlocked  out  1  high while state is UNLOCK.
- alarm  out  1  high while state is ALARM.
- prog_done  out  1  one-cycle pulse when a new code is committed.
- code_set  out  1  a code has been programmed since reset.
- digit_count  out  $clog2(DIGITS+1)  digits captured in the current sequence.
- attempt_count  out  $clog2(MAX_ATTEMPTS+1)  consecutive failures.
- last_digit  out  4  last accepted digit, for the 7-segment display.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - Stored code all 4'h0; entry shift register cleared.
  - code_set=0, digit_count=0, attempt_count=0, last_digit=0.
  - unlocked=0, alarm=0, prog_done=0; all timers cleared.
  - rst overrides every other input, including mid-sequence.
- States: IDLE, ENTER, PROG, CHECK, UNLOCK, ALARM.
- Digit accept:
  - A key_valid with key_code<=9 in IDLE/ENTER/PROG shifts the digit into the entry register (first digit ends up most significant).
  - digit_count increments and last_digit updates.
  - The ENTRY_TIMEOUT counter reloads.
- IDLE:
  - On the first valid digit: mode=1 and code_set=0 -> PROG.
  - mode=1 and code_set=1 -> digit ignored; state stays IDLE. Reprogramming is only allowed from UNLOCK.
  - mode=0 -> ENTER.
- ENTER:
  - When the DIGITS-th digit is accepted at edge n, state=CHECK after edge n.
  - CHECK does a full-width compare against the stored code.
  - Match: UNLOCK after edge n+1, so unlocked is high from edge n+1; attempt_count=0.
  - Mismatch: attempt_count+1. If the new count equals MAX_ATTEMPTS -> ALARM, otherwise -> IDLE.
  - Entry register and digit_count clear on leaving CHECK.
- PROG:
  - After DIGITS digits, the entry register is copied to the stored code.
  - code_set=1, prog_done pulses for 1 cycle, then IDLE.
- UNLOCK:
  - key_valid with a digit and mode=1 -> PROG (that digit is the first captured); mode=0 digits are ignored.
  - relock=1 or UNLOCK_CYCLES elapsed -> IDLE.
  - The relock timer starts on UNLOCK entry and is not reloaded by keys.
- ALARM:
  - All keys are ignored.
  - alarm_clr -> IDLE, attempt_count=0.
  - alarm_clr and key_valid in the same cycle: clear wins; the key is dropped.
- Clear key (4'hA) in ENTER/PROG: discard the partial entry, go to IDLE, digit_count=0, attempt not counted.
- Timeout: in ENTER/PROG with no accepted key for ENTRY_TIMEOUT cycles -> IDLE, partial entry discarded, attempt not counted.
- Ignored keys:
  - Codes B-F are ignored everywhere and do not reload the timeout.
  - key_valid during CHECK is ignored.
- Mode handling:
  - mode changes mid-sequence have no effect.
  - In ENTER, mode=1 keys are treated as digits.
- alarm_clr outside ALARM has no effect; relock outside UNLOCK has no effect.
- All outputs are registered or decoded directly from the state register; there are no combinational paths from inputs to outputs.

Test Plan:
- Programming: after reset, mode=1, keys 2,1,9,3,5,4,8,8 -> prog_done pulses once, code_set=1.
  - Then mode=0 with the same keys -> CHECK one cycle after the 8th key, unlocked=1 the next cycle, attempt_count=0.
- Wrong code: enter 2,1,9,3,5,4,8,7 three times (MAX_ATTEMPTS=3) -> attempt_count 1, 2, then alarm=1 with attempt_count=3.
  - Digits during ALARM leave digit_count=0.
  - alarm_clr together with key_valid -> IDLE, attempt_count=0, key dropped.
- Clear and timeout: 4 digits then 4'hA -> digit_count=0, attempt_count unchanged.
  - 3 digits then ENTRY_TIMEOUT idle cycles -> IDLE, digit_count=0, attempt_count unchanged.
- Relock: after unlock, UNLOCK_CYCLES=500 with no relock -> unlocked drops exactly 500 cycles after rising.
  - A second unlock followed by relock=1 -> unlocked=0 next cycle.
- Reprogramming: from UNLOCK, mode=1 keys 1..8 -> new code committed; the old code now fails and the new code unlocks.
  - From IDLE with code_set=1, mode=1 digits are ignored.
- Reset mid-entry: rst during the 5th digit -> all outputs return to reset values.
  - The previously stored code is lost (all zeros), so code 00000000 now unlocks.

Source files
------------

// File: rtl/passcode_lock_ctrl.sv
// passcode_lock_ctrl: keypad passcode lock with programmable DIGITS-long BCD code.
//
// Accepts strobed keypad digits and either programs a new code (mode=1) or
// compares an entered sequence against the stored one (mode=0). It also has an
// attempt limit with alarm, a clear key, an entry inactivity timeout and an
// automatic relock.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   key_valid      one-cycle strobe qualifying key_code
//   key_code       0-9 digit, 4'hA clear, 4'hB-4'hF ignored
//   mode           1 = program, 0 = enter (sampled on first digit only)
//   relock         forces UNLOCK -> IDLE
//   alarm_clr      clears ALARM and the attempt count
//   unlocked       high while in UNLOCK
//   alarm          high while in ALARM
//   prog_done      one-cycle pulse when a new code is committed
//   code_set       a code has been programmed since reset
//   digit_count    digits captured in the current sequence
//   attempt_count  consecutive failed entries
//   last_digit     last accepted digit, for the display
module passcode_lock_ctrl #(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned MAX_ATTEMPTS  = 3,
  parameter int unsigned ENTRY_TIMEOUT = 1000,
  parameter int unsigned UNLOCK_CYCLES = 500
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              key_valid,
  input  logic [3:0]                        key_code,
  input  logic                              mode,
  input  logic                              relock,
  input  logic                              alarm_clr,
  output logic                              unlocked,
  output logic                              alarm,
  output logic                              prog_done,
  output logic                              code_set,
  output logic [$clog2(DIGITS+1)-1:0]       digit_count,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempt_count,
  output logic [3:0]                        last_digit
);

  localparam int unsigned CntW  = $clog2(DIGITS + 1);
  localparam int unsigned AttW  = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned CodeW = 4 * DIGITS;
  localparam int unsigned TMax  = (ENTRY_TIMEOUT > UNLOCK_CYCLES) ? ENTRY_TIMEOUT
                                                                  : UNLOCK_CYCLES;
  localparam int unsigned TimW  = $clog2(TMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StEnter,
    StProg,
    StCheck,
    StUnlock,
    StAlarm
  } state_e;

  state_e           state_q, state_d;
  logic [CodeW-1:0] code_q, code_d;
  logic [CodeW-1:0] entry_q, entry_d;
  logic             code_set_q, code_set_d;
  logic [CntW-1:0]  digit_count_q, digit_count_d;
  logic [AttW-1:0]  attempt_q, attempt_d;
  logic [3:0]       last_digit_q, last_digit_d;
  logic             prog_done_q, prog_done_d;
  // Shared timer: idle cycles in ENTER/PROG, elapsed cycles in UNLOCK.
  logic [TimW-1:0]  timer_q, timer_d;

  logic             is_digit, is_clear, last_cnt, entry_expired, unlock_expired;
  logic             accept, commit, discard;
  logic [CodeW-1:0] entry_shift;

  always_comb begin
    is_digit       = key_valid && (key_code <= 4'd9);
    is_clear       = key_valid && (key_code == 4'hA);
    last_cnt       = (digit_count_q == CntW'(DIGITS - 1));
    entry_expired  = (timer_q == TimW'(ENTRY_TIMEOUT - 1));
    unlock_expired = (timer_q == TimW'(UNLOCK_CYCLES - 1));
    // First digit ends up most significant.
    entry_shift    = {entry_q[CodeW-5:0], key_code};
  end

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    entry_d       = entry_q;
    code_set_d    = code_set_q;
    digit_count_d = digit_count_q;
    attempt_d     = attempt_q;
    last_digit_d  = last_digit_q;
    prog_done_d   = 1'b0;
    timer_d       = '0;
    accept        = 1'b0;
    commit        = 1'b0;
    discard       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_digit) begin
          if (!mode) begin
            accept  = 1'b1;
            state_d = StEnter;
          end else if (!code_set_q) begin
            accept  = 1'b1;
            state_d = StProg;
          end
          // mode=1 with a code already set: reprogramming only from UNLOCK.
        end
      end

      StEnter: begin
        if (is_digit) begin
          accept = 1'b1;
          if (last_cnt) state_d = StCheck;
        end else if (is_clear || entry_expired) begin
          discard = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TimW'(1);
        end
      end

      StProg: begin
        if (is_digit) begin
          accept = 1'b1;
          if (last_cnt) begin
            commit  = 1'b1;
            state_d = StIdle;
          end
        end else if (is_clear || entry_expired) begin
          discard = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TimW'(1);
        end
      end

      StCheck: begin
        discard = 1'b1;
        if (entry_q == code_q) begin
          attempt_d = '0;
          state_d   = StUnlock;
        end else begin
          attempt_d = attempt_q + AttW'(1);
          state_d   = (attempt_q == AttW'(MAX_ATTEMPTS - 1)) ? StAlarm : StIdle;
        end
      end

      StUnlock: begin
        if (relock || unlock_expired) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TimW'(1);
          if (is_digit && mode) begin
            accept  = 1'b1;
            state_d = StProg;
          end
        end
      end

      StAlarm: begin
        // Clear wins over any simultaneous key; keys are dropped here anyway.
        if (alarm_clr) begin
          attempt_d = '0;
          state_d   = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (accept) begin
      entry_d       = entry_shift;
      digit_count_d = digit_count_q + CntW'(1);
      last_digit_d  = key_code;
      timer_d       = '0;
    end
    if (commit) begin
      code_d      = entry_shift;
      code_set_d  = 1'b1;
      prog_done_d = 1'b1;
    end
    if (discard || commit) begin
      entry_d       = '0;
      digit_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      code_q        <= '0;
      entry_q       <= '0;
      code_set_q    <= 1'b0;
      digit_count_q <= '0;
      attempt_q     <= '0;
      last_digit_q  <= '0;
      prog_done_q   <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      entry_q       <= entry_d;
      code_set_q    <= code_set_d;
      digit_count_q <= digit_count_d;
      attempt_q     <= attempt_d;
      last_digit_q  <= last_digit_d;
      prog_done_q   <= prog_done_d;
      timer_q       <= timer_d;
    end
  end

  assign unlocked      = (state_q == StUnlock);
  assign alarm         = (state_q == StAlarm);
  assign prog_done     = prog_done_q;
  assign code_set      = code_set_q;
  assign digit_count   = digit_count_q;
  assign attempt_count = attempt_q;
  assign last_digit    = last_digit_q;

endmodule

// File: tb/tb_passcode_lock_ctrl.sv
// Directed bench for passcode_lock_ctrl with default parameters
// (DIGITS=8, MAX_ATTEMPTS=3, ENTRY_TIMEOUT=1000, UNLOCK_CYCLES=500).
module tb_passcode_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       mode;
  logic       relock;
  logic       alarm_clr;
  logic       unlocked;
  logic       alarm;
  logic       prog_done;
  logic       code_set;
  logic [3:0] digit_count;
  logic [1:0] attempt_count;
  logic [3:0] last_digit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  passcode_lock_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .mode          (mode),
    .relock        (relock),
    .alarm_clr     (alarm_clr),
    .unlocked      (unlocked),
    .alarm         (alarm),
    .prog_done     (prog_done),
    .code_set      (code_set),
    .digit_count   (digit_count),
    .attempt_count (attempt_count),
    .last_digit    (last_digit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic enter8(input logic [31:0] c);
    for (int i = 0; i < 8; i++) press(c[4*(7-i) +: 4]);
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    mode      = 1'b0;
    relock    = 1'b0;
    alarm_clr = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    chk("rst_unlocked", unlocked, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_prog_done", prog_done, 0);
    chk("rst_code_set", code_set, 0);
    chk("rst_digit_count", digit_count, 0);
    chk("rst_attempt", attempt_count, 0);
    chk("rst_last_digit", last_digit, 0);

    // Program 21935488.
    mode = 1'b1;
    press(4'd2); press(4'd1); press(4'd9); press(4'd3);
    press(4'd5); press(4'd4); press(4'd8);
    chk("prog_count7", digit_count, 7);
    chk("prog_no_early_done", prog_done, 0);
    press(4'd8);
    chk("prog_done_pulse", prog_done, 1);
    chk("prog_code_set", code_set, 1);
    chk("prog_count_clr", digit_count, 0);
    step();
    chk("prog_done_one_cycle", prog_done, 0);

    // Enter the correct code: CHECK after the 8th key, UNLOCK one edge later.
    mode = 1'b0;
    enter8(32'h21935488);
    chk("check_count8", digit_count, 8);
    chk("check_not_yet_unlocked", unlocked, 0);
    step();
    chk("unlock", unlocked, 1);
    chk("unlock_attempt", attempt_count, 0);
    chk("unlock_count_clr", digit_count, 0);
    chk("unlock_last_digit", last_digit, 8);

    // Auto-relock exactly 500 cycles after unlocked rose.
    repeat (499) step();
    chk("relock_499_still_open", unlocked, 1);
    step();
    chk("relock_500_closed", unlocked, 0);

    // Three wrong entries raise the alarm.
    for (int a = 1; a <= 3; a++) begin
      enter8(32'h21935487);
      step();
      chk("wrong_attempt", attempt_count, a);
      chk("wrong_alarm", alarm, (a == 3) ? 1 : 0);
    end

    press(4'd5);
    chk("alarm_key_ignored", digit_count, 0);
    chk("alarm_held", alarm, 1);

    // Clear and key in the same cycle: clear wins, key dropped.
    alarm_clr = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'd3;
    step();
    alarm_clr = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    chk("alarm_clr_alarm", alarm, 0);
    chk("alarm_clr_attempt", attempt_count, 0);
    chk("alarm_clr_key_dropped", digit_count, 0);
    chk("alarm_clr_last_digit", last_digit, 7);

    // One failure so the clear/timeout cases can show attempt_count is kept.
    enter8(32'h21935487);
    step();
    chk("pre_clear_attempt", attempt_count, 1);

    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("clear_pre_count", digit_count, 4);
    press(4'hA);
    chk("clear_count", digit_count, 0);
    chk("clear_attempt", attempt_count, 1);

    // Timeout: ignored key B must not reload the idle timer.
    press(4'd5); press(4'd6); press(4'd7);
    press(4'hB);
    chk("keyB_ignored", digit_count, 3);
    repeat (998) step();
    chk("timeout_999_kept", digit_count, 3);
    step();
    chk("timeout_1000_cleared", digit_count, 0);
    chk("timeout_attempt", attempt_count, 1);
    chk("timeout_last_digit", last_digit, 7);

    // Fresh full entry after the discarded partial one unlocks.
    enter8(32'h21935488);
    step();
    chk("post_timeout_unlock", unlocked, 1);
    chk("post_timeout_attempt", attempt_count, 0);

    relock = 1'b1;
    step();
    relock = 1'b0;
    chk("manual_relock", unlocked, 0);

    // Reprogram from UNLOCK to 12345678.
    enter8(32'h21935488);
    step();
    chk("reprog_unlock", unlocked, 1);
    mode = 1'b1;
    press(4'd1);
    chk("reprog_left_unlock", unlocked, 0);
    chk("reprog_first_digit", digit_count, 1);
    for (int d = 2; d <= 8; d++) press(4'(d));
    chk("reprog_done", prog_done, 1);
    mode = 1'b0;
    enter8(32'h21935488);
    step();
    chk("old_code_rejected", unlocked, 0);
    chk("old_code_attempt", attempt_count, 1);
    enter8(32'h12345678);
    step();
    chk("new_code_unlock", unlocked, 1);
    chk("new_code_attempt", attempt_count, 0);
    relock = 1'b1;
    step();
    relock = 1'b0;

    // mode=1 in IDLE with a code already set is ignored.
    mode = 1'b1;
    press(4'd9);
    chk("idle_prog_ignored_count", digit_count, 0);
    chk("idle_prog_ignored_last", last_digit, 8);
    step();
    chk("idle_prog_no_done", prog_done, 0);
    mode = 1'b0;

    // A failure before reset so attempt_count has something to clear.
    enter8(32'h00000000);
    step();
    chk("zero_rejected", attempt_count, 1);

    // Reset during the 5th digit.
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    rst       = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'd5;
    step();
    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    chk("midrst_count", digit_count, 0);
    chk("midrst_last_digit", last_digit, 0);
    chk("midrst_code_set", code_set, 0);
    chk("midrst_attempt", attempt_count, 0);
    chk("midrst_unlocked", unlocked, 0);
    chk("midrst_alarm", alarm, 0);
    chk("midrst_prog_done", prog_done, 0);

    // Stored code reverted to zeros.
    enter8(32'h00000000);
    step();
    chk("zero_code_unlock", unlocked, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
